// File: rtl/ffs.sv
// ffs: limb-serial subtractor over GF(2^255-19).
// Computes out = (a_i - b_i) mod p with a 64-bit subtract limb and a
// 64-bit add-p correction limb per cycle; start/done timing matches the
// field adder so the two units are interchangeable in a schedule.
module ffs (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a_i,
  input  logic [254:0] b_i,
  output logic [254:0] out,
  output logic         done,
  output logic         busy
);

  localparam int unsigned LIMB_W = 64;
  localparam logic [255:0] P =
    256'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L0,
    S_L1,
    S_L2,
    S_L3,
    S_FIX
  } state_t;

  state_t state, state_next;

  logic [255:0] a_r, b_r;     // captured operands, zero-extended
  logic [255:0] d_r;          // a - b, raw two's-complement difference
  logic [255:0] s_r;          // d + p, the borrow-corrected candidate
  logic         bor_r;        // borrow out of the last subtract limb
  logic         cry_r;        // carry out of the last correction limb

  // Per-cycle limb selection and chaining inputs.
  logic              sub_en, add_en;
  logic [1:0]        sub_k, add_k;
  logic              bor_in, cry_in;
  logic [LIMB_W:0]   sub_res, add_res;
  logic [255:0]      s_full;

  // Next-state decode and limb arithmetic for the current slot.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    sub_en     = 1'b0;
    add_en     = 1'b0;
    sub_k      = 2'd0;
    add_k      = 2'd0;
    bor_in     = bor_r;
    cry_in     = cry_r;
    case (state)
      S_IDLE: if (start) state_next = S_L0;
      S_L0: begin
        sub_en     = 1'b1;
        sub_k      = 2'd0;
        bor_in     = 1'b0;
        state_next = S_L1;
      end
      S_L1: begin
        sub_en     = 1'b1;
        sub_k      = 2'd1;
        add_en     = 1'b1;
        add_k      = 2'd0;
        cry_in     = 1'b0;
        state_next = S_L2;
      end
      S_L2: begin
        sub_en     = 1'b1;
        sub_k      = 2'd2;
        add_en     = 1'b1;
        add_k      = 2'd1;
        state_next = S_L3;
      end
      S_L3: begin
        sub_en     = 1'b1;
        sub_k      = 2'd3;
        add_en     = 1'b1;
        add_k      = 2'd2;
        state_next = S_FIX;
      end
      S_FIX: begin
        add_en     = 1'b1;
        add_k      = 2'd3;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Bit 64 of a 65-bit difference is the borrow; of a 65-bit sum, the carry.
    sub_res = {1'b0, a_r[{sub_k, 6'd0} +: LIMB_W]}
            - {1'b0, b_r[{sub_k, 6'd0} +: LIMB_W]}
            - {{LIMB_W{1'b0}}, bor_in};
    add_res = {1'b0, d_r[{add_k, 6'd0} +: LIMB_W]}
            + {1'b0, P[{add_k, 6'd0} +: LIMB_W]}
            + {{LIMB_W{1'b0}}, cry_in};

    // Top correction limb is only ready in FIX, so splice it in combinationally.
    s_full           = s_r;
    s_full[255:192]  = add_res[LIMB_W-1:0];
  end

  // State, datapath and output registers.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the wide operand/partial registers are reset too, because a reset
  // must leave no trace of an aborted operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      d_r   <= '0;
      s_r   <= '0;
      bor_r <= 1'b0;
      cry_r <= 1'b0;
      out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;

      if (state == S_IDLE && start) begin
        a_r   <= {1'b0, a_i};
        b_r   <= {1'b0, b_i};
        bor_r <= 1'b0;
        cry_r <= 1'b0;
        busy  <= 1'b1;
      end

      if (sub_en) begin
        d_r[{sub_k, 6'd0} +: LIMB_W] <= sub_res[LIMB_W-1:0];
        bor_r                        <= sub_res[LIMB_W];
      end

      if (add_en) begin
        s_r[{add_k, 6'd0} +: LIMB_W] <= add_res[LIMB_W-1:0];
        cry_r                        <= add_res[LIMB_W];
      end

      // Final borrow set means a < b, so the p-corrected value is the answer.
      if (state == S_FIX) begin
        out  <= bor_r ? s_full[254:0] : d_r[254:0];
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ffs.sv
// tb_ffs: self-checking bench for the GF(2^255-19) subtractor.
// A cycle-level reference (latency counter + modular arithmetic) predicts
// out/done/busy; a compare process checks them on every falling edge.
module tb_ffs;

  localparam logic [255:0] P =
    256'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFED;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [254:0] a_i = '0;
  logic [254:0] b_i = '0;
  logic [254:0] out;
  logic         done;
  logic         busy;

  int n_vec  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  bit cmp_en = 1'b0;

  ffs dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_i   (a_i),
    .b_i   (b_i),
    .out   (out),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference: (a - b) mod p by plain arithmetic.
  function automatic logic [254:0] ref_sub(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] r;
    if (a >= b) r = {1'b0, a} - {1'b0, b};
    else        r = {1'b0, a} + P - {1'b0, b};
    return r[254:0];
  endfunction

  function automatic logic [254:0] rand_fe();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[255] = 1'b0;
    if (r >= P) r = r - P;
    case ($urandom_range(0, 9))
      0: r = '0;
      1: r = 256'd1;
      2: r = P - 256'd1;
      3: r = P - 256'd2;
      4: r = 256'd1 << ($urandom_range(0, 3) * 64);
      default: ;
    endcase
    return r[254:0];
  endfunction

  task automatic check(input string name, input logic [254:0] act, input logic [254:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-level model: accept start only when idle, result 5 edges later.
  logic [254:0] exp_out  = '0;
  logic [254:0] pend     = '0;
  logic         exp_done = 1'b0;
  logic         exp_busy = 1'b0;
  int           cnt      = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_out  = '0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      cnt      = 0;
    end else begin
      exp_done = 1'b0;
      if (cnt == 0) begin
        if (start) begin
          pend     = ref_sub(a_i, b_i);
          cnt      = 5;
          exp_busy = 1'b1;
          n_acc++;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          exp_out  = pend;
          exp_done = 1'b1;
          exp_busy = 1'b0;
        end
      end
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out",  out,           exp_out);
      check("done", 255'(done),    255'(exp_done));
      check("busy", 255'(busy),    255'(exp_busy));
    end
  end

  // One directed operation; operands are scrambled after capture.
  task automatic do_op(input logic [254:0] a, input logic [254:0] b, input logic [254:0] lit,
                       input string name);
    bit got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a_i   = a;
    b_i   = b;
    @(negedge clk);
    start = 1'b0;
    a_i   = rand_fe();
    b_i   = rand_fe();
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done"}, 255'(got), 255'd1);
    check(name, out, lit);
  endtask

  initial begin
    logic [254:0] pm1, pm2, p64, p192;
    int cyc;
    pm1  = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEC;
    pm2  = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB;
    p64  = 255'd1 << 64;
    p192 = 255'd1 << 192;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out",  out,        255'd0);
    check("rst_done", 255'(done), 255'd0);
    check("rst_busy", 255'(busy), 255'd0);
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // Latency/handshake of the first op, sampled after each edge.
    @(negedge clk);
    start = 1'b1; a_i = 255'd5; b_i = 255'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy_e0", 255'(busy), 255'd1);
    repeat (4) @(negedge clk);
    check("busy_e4", 255'(busy), 255'd1);
    check("done_e4", 255'(done), 255'd0);
    @(negedge clk);
    check("done_e5", 255'(done), 255'd1);
    check("busy_e5", 255'(busy), 255'd0);
    check("out_5m3", out,        255'd2);
    @(negedge clk);
    check("done_e6", 255'(done), 255'd0);
    check("hold",    out,        255'd2);

    // Directed values.
    do_op(255'd3,      255'd5,      pm2,                "3m5");
    do_op(255'h1234,   255'h1234,   255'd0,             "eq");
    do_op(255'd0,      pm1,         255'd1,             "0mpm1");
    do_op(pm1,         255'd0,      pm1,                "pm1m0");
    do_op(p64,         255'd1,      255'hFFFF_FFFF_FFFF_FFFF, "b64");
    do_op(p192,        255'd1,      p192 - 255'd1,      "b192");

    // Reset while the op is in L2: aborted, no done, out cleared.
    @(negedge clk);
    start = 1'b1; a_i = 255'd9; b_i = 255'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_out",  out,        255'd0);
    check("abort_busy", 255'(busy), 255'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_nodone", 255'(done), 255'd0);
    do_op(255'd100, 255'd1, 255'd99, "post_rst");

    // Start re-asserted during L1 with other operands is ignored.
    @(negedge clk);
    start = 1'b1; a_i = 255'd50; b_i = 255'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a_i = 255'd7; b_i = 255'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_done", 255'(done), 255'd1);
    check("ign_out",  out,        255'd42);
    repeat (6) @(negedge clk);
    check("ign_noretrig", 255'(busy), 255'd0);

    // Random reduced pairs with mostly back-to-back starts.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 85000) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) != 0);
      a_i   = rand_fe();
      b_i   = rand_fe();
      cyc++;
    end
    check("rand_budget", 255'(n_acc >= 10000), 255'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
